// File: rtl/gan_tile_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gan_tile_scheduler : splits one layer descriptor into array-sized tiles and |
// |                      sequences the systolic-array controller tile by tile.  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module gan_tile_scheduler #(
  parameter int ARRAY_SIZE = 16,
  parameter int TIMEOUT    = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic        cfg_split,
  input  logic [7:0]  cfg_ofmap_size,
  input  logic [7:0]  cfg_num_channels,
  input  logic [2:0]  cfg_kernel_size,
  input  logic        abort,
  input  logic        array_done,
  output logic        array_start,
  output logic        operation_mode,
  output logic [7:0]  ofmap_size,
  output logic [7:0]  num_channels,
  output logic [2:0]  kernel_size,
  output logic [7:0]  tile_row,
  output logic [7:0]  tile_col,
  output logic [15:0] tiles_done,
  output logic        busy,
  output logic        layer_done,
  output logic        err
);

  localparam int              WD_W       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT - 1);
  localparam logic [8:0]      STEP_NORM  = 9'(ARRAY_SIZE);
  localparam logic [8:0]      STEP_SPLIT = 9'(ARRAY_SIZE / 2);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_NEXT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]      state_q, state_d;
  logic            split_q, split_d;
  logic [7:0]      ofmap_q, ofmap_d;
  logic [7:0]      nch_q, nch_d;
  logic [2:0]      ks_q, ks_d;
  logic [7:0]      row_q, row_d;
  logic [7:0]      col_q, col_d;
  logic [15:0]     tiles_q, tiles_d;
  logic [15:0]     total_q, total_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;

  // Tile grid edge computed in 9 bits so ofmap_size + T - 1 cannot wrap.
  logic [8:0]  w_step_cfg, w_step_cur, w_n_tiles, w_col_sum, w_row_sum;
  logic [15:0] w_total_cfg, w_tiles_inc;
  logic        w_cfg_bad;

  assign w_step_cfg  = cfg_split ? STEP_SPLIT : STEP_NORM;
  assign w_step_cur  = split_q ? STEP_SPLIT : STEP_NORM;
  assign w_n_tiles   = ({1'b0, cfg_ofmap_size} + w_step_cfg - 9'd1) / w_step_cfg;
  assign w_total_cfg = {7'd0, w_n_tiles} * {7'd0, w_n_tiles};
  assign w_tiles_inc = tiles_q + 16'd1;
  assign w_col_sum   = {1'b0, col_q} + w_step_cur;
  assign w_row_sum   = {1'b0, row_q} + w_step_cur;
  assign w_cfg_bad   = (cfg_ofmap_size == 8'd0) || (cfg_num_channels == 8'd0) ||
                       (cfg_kernel_size == 3'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      split_q <= 1'b0;
      ofmap_q <= '0;
      nch_q   <= '0;
      ks_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      tiles_q <= '0;
      total_q <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      split_q <= split_d;
      ofmap_q <= ofmap_d;
      nch_q   <= nch_d;
      ks_q    <= ks_d;
      row_q   <= row_d;
      col_q   <= col_d;
      tiles_q <= tiles_d;
      total_q <= total_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    split_d = split_q;
    ofmap_d = ofmap_q;
    nch_d   = nch_q;
    ks_d    = ks_q;
    row_d   = row_q;
    col_d   = col_q;
    tiles_d = tiles_q;
    total_d = total_q;
    wd_d    = wd_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          split_d = cfg_split;
          ofmap_d = cfg_ofmap_size;
          nch_d   = cfg_num_channels;
          ks_d    = cfg_kernel_size;
          row_d   = '0;
          col_d   = '0;
          tiles_d = '0;
          total_d = w_total_cfg;
          if (w_cfg_bad) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done pulse on the final watchdog cycle still counts as success.
        if (array_done) begin
          tiles_d = w_tiles_inc;
          state_d = (w_tiles_inc == total_q) ? S_DONE : S_NEXT;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_NEXT: begin
        if (w_col_sum >= {1'b0, ofmap_q}) begin
          col_d = '0;
          row_d = w_row_sum[7:0];
        end else begin
          col_d = w_col_sum[7:0];
        end
        state_d = S_ISSUE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      tiles_d = tiles_q;
      err_d   = err_q;
      wd_d    = wd_q;
      row_d   = row_q;
      col_d   = col_q;
    end
  end

  always_comb begin
    cfg_ready   = (state_q == S_IDLE);
    busy        = (state_q != S_IDLE);
    array_start = (state_q == S_ISSUE);
    layer_done  = (state_q == S_DONE);
  end

  assign operation_mode = split_q;
  assign ofmap_size     = ofmap_q;
  assign num_channels   = nch_q;
  assign kernel_size    = ks_q;
  assign tile_row       = row_q;
  assign tile_col       = col_q;
  assign tiles_done     = tiles_q;
  assign err            = err_q;

endmodule
`default_nettype wire

// File: tb/tb_gan_tile_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_gan_tile_scheduler : randomized self-checking bench for the scheduler.   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_gan_tile_scheduler;

  localparam int ARRAY_SIZE = 16;
  localparam int TIMEOUT    = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic        cfg_split = 1'b0;
  logic [7:0]  cfg_ofmap_size = '0;
  logic [7:0]  cfg_num_channels = '0;
  logic [2:0]  cfg_kernel_size = '0;
  logic        abort = 1'b0;
  logic        array_done = 1'b0;
  logic        array_start;
  logic        operation_mode;
  logic [7:0]  ofmap_size;
  logic [7:0]  num_channels;
  logic [2:0]  kernel_size;
  logic [7:0]  tile_row;
  logic [7:0]  tile_col;
  logic [15:0] tiles_done;
  logic        busy;
  logic        layer_done;
  logic        err;

  int n_pass = 0;
  int n_total = 0;

  gan_tile_scheduler #(.ARRAY_SIZE(ARRAY_SIZE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_split(cfg_split),
    .cfg_ofmap_size(cfg_ofmap_size), .cfg_num_channels(cfg_num_channels),
    .cfg_kernel_size(cfg_kernel_size), .abort(abort), .array_done(array_done),
    .array_start(array_start), .operation_mode(operation_mode),
    .ofmap_size(ofmap_size), .num_channels(num_channels), .kernel_size(kernel_size),
    .tile_row(tile_row), .tile_col(tile_col), .tiles_done(tiles_done),
    .busy(busy), .layer_done(layer_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic send_cfg(input bit sp, input logic [7:0] ofm, input logic [7:0] nch,
                          input logic [2:0] ks);
    int w;
    w = 0;
    while (!cfg_ready && w < 200) begin @(negedge clk); w++; end
    chk("cfg_ready_before_accept", cfg_ready, 1);
    cfg_valid = 1'b1; cfg_split = sp; cfg_ofmap_size = ofm;
    cfg_num_channels = nch; cfg_kernel_size = ks;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // mode 0: all tiles complete; 1: withhold done for tile stop; 2: abort in WAIT of tile stop
  task automatic run_layer(input bit sp, input logic [7:0] ofm, input logic [7:0] nch,
                           input logic [2:0] ks, input int mode, input int stop);
    int t, n, total, starts, cyc, dly, adly, tstart, budget, exp_starts, exp_tiles;
    bit bad, aborted, seen_ld;
    t     = sp ? ARRAY_SIZE / 2 : ARRAY_SIZE;
    bad   = (ofm == 0) || (nch == 0) || (ks == 0);
    n     = (int'(ofm) + t - 1) / t;
    total = n * n;
    if (bad) mode = 0;
    budget = 2000 + total * 16 + TIMEOUT;
    starts = 0; cyc = 0; dly = -1; adly = -1; tstart = 0; aborted = 0; seen_ld = 0;
    send_cfg(sp, ofm, nch, ks);
    if (!bad) chk("err_cleared_on_accept", err, 0);
    while (1) begin
      array_done = 1'b0;
      abort = 1'b0;
      if (aborted) begin
        chk("abort_idle_busy", busy, 0);
        chk("abort_idle_ready", cfg_ready, 1);
        chk("abort_tiles_done", tiles_done, stop - 1);
        chk("abort_err_unchanged", err, 0);
        chk("abort_ofmap_hold", ofmap_size, ofm);
        repeat (3) begin
          @(negedge clk);
          if (layer_done) seen_ld = 1;
        end
        chk("abort_no_layer_done", seen_ld, 0);
        break;
      end
      if (layer_done) begin
        if (mode == 2) chk("layer_done_before_abort", layer_done, 0);
        exp_starts = bad ? 0 : (mode == 1 ? stop : total);
        exp_tiles  = bad ? 0 : (mode == 1 ? stop - 1 : total);
        chk("ld_starts", starts, exp_starts);
        chk("ld_tiles_done", tiles_done, exp_tiles);
        chk("ld_err", err, (bad || mode == 1) ? 1 : 0);
        if (bad) chk("bad_cfg_ld_latency", cyc <= 1, 1);
        if (mode == 1)
          chk("timeout_latency", (cyc - tstart >= TIMEOUT) && (cyc - tstart <= TIMEOUT + 1), 1);
        @(negedge clk);
        chk("post_ld_ready", cfg_ready, 1);
        chk("post_ld_layer_done_pulse", layer_done, 0);
        chk("post_ld_tiles_hold", tiles_done, exp_tiles);
        chk("post_ld_ofmap_hold", ofmap_size, ofm);
        break;
      end
      if (array_start) begin
        chk("tile_row", tile_row, (starts / n) * t);
        chk("tile_col", tile_col, (starts % n) * t);
        chk("op_mode", operation_mode, sp);
        chk("cfg_hold", {ofmap_size, num_channels, kernel_size}, {ofm, nch, ks});
        starts++;
        if (mode == 1 && starts == stop) begin dly = -1; tstart = cyc; end
        else if (mode == 2 && starts == stop) adly = $urandom_range(1, 3);
        else dly = $urandom_range(1, 4);
      end else if (dly > 0) begin
        dly--;
        if (dly == 0) begin array_done = 1'b1; dly = -1; end
      end else if (adly > 0) begin
        adly--;
        if (adly == 0) begin abort = 1'b1; adly = -1; aborted = 1; end
      end
      if (cyc >= budget) begin
        chk("layer_end_within_budget", 0, 1);
        break;
      end
      cyc++;
      @(negedge clk);
    end
    array_done = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    int w;
    bit sp;
    logic [7:0] ofm, nch;
    logic [2:0] ks;
    int md, st, tt, nn;
    @(negedge clk);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_outputs", {array_start, layer_done, err, operation_mode}, 0);
    chk("rst_latched", {ofmap_size, num_channels, kernel_size, tile_row, tile_col, tiles_done}, 0);
    reset = 1'b0;
    @(negedge clk);

    run_layer(1'b0, 8'd32, 8'd3, 3'd3, 0, 0);
    run_layer(1'b1, 8'd20, 8'd8, 3'd3, 0, 0);
    run_layer(1'b0, 8'd32, 8'd0, 3'd3, 0, 0);
    run_layer(1'b0, 8'd32, 8'd4, 3'd3, 1, 1);
    run_layer(1'b0, 8'd17, 8'd4, 3'd3, 0, 0);
    run_layer(1'b0, 8'd32, 8'd4, 3'd3, 2, 2);

    // reset in the middle of WAIT, then a stray done pulse
    send_cfg(1'b0, 8'd32, 8'd5, 3'd3);
    w = 0;
    while (!array_start && w < 10) begin @(negedge clk); w++; end
    chk("pre_reset_start_seen", array_start, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_ready", cfg_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_outputs", {array_start, layer_done, err, operation_mode}, 0);
    chk("midrst_latched", {ofmap_size, num_channels, kernel_size, tile_row, tile_col, tiles_done}, 0);
    reset = 1'b0;
    array_done = 1'b1;
    @(negedge clk);
    array_done = 1'b0;
    chk("stray_done_busy", busy, 0);
    chk("stray_done_tiles", tiles_done, 0);
    @(negedge clk);
    chk("stray_done_no_activity", {array_start, layer_done}, 0);

    for (int i = 0; i < 25; i++) begin
      sp  = 1'($urandom_range(0, 1));
      ofm = 8'($urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 48));
      nch = 8'($urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 255));
      ks  = 3'($urandom_range(0, 7));
      tt  = sp ? ARRAY_SIZE / 2 : ARRAY_SIZE;
      nn  = (int'(ofm) + tt - 1) / tt;
      md  = $urandom_range(0, 5);
      md  = (md >= 3) ? 0 : md;
      st  = (nn > 0) ? $urandom_range(1, nn * nn) : 1;
      run_layer(sp, ofm, nch, ks, md, st);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
